// File: rtl/conv2_window_buf.sv
// Streaming 5x5 sliding-window generator over a raster-order feature map.
// Optional frame_done pulse is enabled by defining CONV2_WINDOW_FRAME_DONE_EN.
module conv2_window_buf #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned HEIGHT    = 12,
  parameter int unsigned DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [DATA_BITS-1:0] data_out_0,
  output logic [DATA_BITS-1:0] data_out_1,
  output logic [DATA_BITS-1:0] data_out_2,
  output logic [DATA_BITS-1:0] data_out_3,
  output logic [DATA_BITS-1:0] data_out_4,
  output logic [DATA_BITS-1:0] data_out_5,
  output logic [DATA_BITS-1:0] data_out_6,
  output logic [DATA_BITS-1:0] data_out_7,
  output logic [DATA_BITS-1:0] data_out_8,
  output logic [DATA_BITS-1:0] data_out_9,
  output logic [DATA_BITS-1:0] data_out_10,
  output logic [DATA_BITS-1:0] data_out_11,
  output logic [DATA_BITS-1:0] data_out_12,
  output logic [DATA_BITS-1:0] data_out_13,
  output logic [DATA_BITS-1:0] data_out_14,
  output logic [DATA_BITS-1:0] data_out_15,
  output logic [DATA_BITS-1:0] data_out_16,
  output logic [DATA_BITS-1:0] data_out_17,
  output logic [DATA_BITS-1:0] data_out_18,
  output logic [DATA_BITS-1:0] data_out_19,
  output logic [DATA_BITS-1:0] data_out_20,
  output logic [DATA_BITS-1:0] data_out_21,
  output logic [DATA_BITS-1:0] data_out_22,
  output logic [DATA_BITS-1:0] data_out_23,
  output logic [DATA_BITS-1:0] data_out_24,
  output logic                 valid_out_buf
`ifdef CONV2_WINDOW_FRAME_DONE_EN
  ,
  output logic                 frame_done
`endif
);

  localparam int unsigned Depth   = 4 * WIDTH + 5;
  localparam int unsigned ColBits = $clog2(WIDTH);
  localparam int unsigned RowBits = $clog2(HEIGHT);

  logic [DATA_BITS-1:0] line_q [Depth];
  logic [DATA_BITS-1:0] line_d [Depth];
  logic [DATA_BITS-1:0] taps_q [25];
  logic [ColBits-1:0]   col_q, col_d;
  logic [RowBits-1:0]   row_q, row_d;
  logic                 valid_q;
  logic                 qualify;
  logic                 last_pos;

  // Entry 0 is the incoming sample, so entry k is the sample accepted k steps earlier.
  always_comb begin
    line_d[0] = data_in;
    for (int i = 1; i < Depth; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  assign qualify  = valid_in && (row_q >= RowBits'(4)) && (col_q >= ColBits'(4));
  assign last_pos = (row_q == RowBits'(HEIGHT - 1)) && (col_q == ColBits'(WIDTH - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_q == ColBits'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RowBits'(HEIGHT - 1)) ? '0 : row_q + RowBits'(1);
      end else begin
        col_d = col_q + ColBits'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) line_q[i] <= '0;
      for (int k = 0; k < 25; k++) taps_q[k] <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= qualify;
      col_q   <= col_d;
      row_q   <= row_d;
      if (valid_in) begin
        for (int i = 0; i < Depth; i++) line_q[i] <= line_d[i];
      end
      // Tap (r,c) sits (4-r) rows and (4-c) columns behind the newest sample.
      if (qualify) begin
        for (int k = 0; k < 25; k++) begin
          taps_q[k] <= line_d[(4 - k / 5) * WIDTH + (4 - k % 5)];
        end
      end
    end
  end

`ifdef CONV2_WINDOW_FRAME_DONE_EN
  logic frame_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= valid_in && last_pos;
    end
  end

  assign frame_done = frame_done_q;
`else
  logic unused_last_pos;
  assign unused_last_pos = last_pos;
`endif

  assign valid_out_buf = valid_q;
  assign data_out_0  = taps_q[0];
  assign data_out_1  = taps_q[1];
  assign data_out_2  = taps_q[2];
  assign data_out_3  = taps_q[3];
  assign data_out_4  = taps_q[4];
  assign data_out_5  = taps_q[5];
  assign data_out_6  = taps_q[6];
  assign data_out_7  = taps_q[7];
  assign data_out_8  = taps_q[8];
  assign data_out_9  = taps_q[9];
  assign data_out_10 = taps_q[10];
  assign data_out_11 = taps_q[11];
  assign data_out_12 = taps_q[12];
  assign data_out_13 = taps_q[13];
  assign data_out_14 = taps_q[14];
  assign data_out_15 = taps_q[15];
  assign data_out_16 = taps_q[16];
  assign data_out_17 = taps_q[17];
  assign data_out_18 = taps_q[18];
  assign data_out_19 = taps_q[19];
  assign data_out_20 = taps_q[20];
  assign data_out_21 = taps_q[21];
  assign data_out_22 = taps_q[22];
  assign data_out_23 = taps_q[23];
  assign data_out_24 = taps_q[24];

endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf: gap-free, gapped, back-to-back and reset-mid-frame runs.
module tb_conv2_window_buf;

  localparam int W  = 12;
  localparam int H  = 12;
  localparam int DB = 12;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DB-1:0] data_in;
  logic [DB-1:0] dout [25];
  logic          valid_out_buf;
`ifdef CONV2_WINDOW_FRAME_DONE_EN
  logic          frame_done;
`endif

  int checks = 0;
  int errors = 0;
  int pulses;
  int held0, held24;

  always #5 clk = ~clk;

  conv2_window_buf #(
    .WIDTH    (W),
    .HEIGHT   (H),
    .DATA_BITS(DB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .data_out_0   (dout[0]),
    .data_out_1   (dout[1]),
    .data_out_2   (dout[2]),
    .data_out_3   (dout[3]),
    .data_out_4   (dout[4]),
    .data_out_5   (dout[5]),
    .data_out_6   (dout[6]),
    .data_out_7   (dout[7]),
    .data_out_8   (dout[8]),
    .data_out_9   (dout[9]),
    .data_out_10  (dout[10]),
    .data_out_11  (dout[11]),
    .data_out_12  (dout[12]),
    .data_out_13  (dout[13]),
    .data_out_14  (dout[14]),
    .data_out_15  (dout[15]),
    .data_out_16  (dout[16]),
    .data_out_17  (dout[17]),
    .data_out_18  (dout[18]),
    .data_out_19  (dout[19]),
    .data_out_20  (dout[20]),
    .data_out_21  (dout[21]),
    .data_out_22  (dout[22]),
    .data_out_23  (dout[23]),
    .data_out_24  (dout[24]),
    .valid_out_buf(valid_out_buf)
`ifdef CONV2_WINDOW_FRAME_DONE_EN
    ,
    .frame_done   (frame_done)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(valid_out_buf), 0);
    for (int k = 0; k < 25; k++) check_eq($sformatf("%s_tap%0d", tag, k), 32'(dout[k]), 0);
`ifdef CONV2_WINDOW_FRAME_DONE_EN
    check_eq({tag, "_frame_done"}, 32'(frame_done), 0);
`endif
  endtask

  // Outputs must hold the last window while no pulse is present.
  task automatic check_hold(input string tag);
    check_eq({tag, "_hold0"}, 32'(dout[0]), held0);
    check_eq({tag, "_hold24"}, 32'(dout[24]), held24);
  endtask

  // Accept one sample whose value equals its raster position within the frame.
  task automatic send(input int pos);
    bit exp_win;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = DB'(pos);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    exp_win  = ((pos / W) >= 4) && ((pos % W) >= 4);
    check_eq($sformatf("valid@%0d", pos), 32'(valid_out_buf), 32'(exp_win));
`ifdef CONV2_WINDOW_FRAME_DONE_EN
    check_eq($sformatf("frame_done@%0d", pos), 32'(frame_done), 32'(pos == N - 1));
`endif
    if (exp_win) begin
      pulses++;
      for (int k = 0; k < 25; k++) begin
        check_eq($sformatf("tap%0d@%0d", k, pos), 32'(dout[k]),
                 pos - (4 - k / 5) * W - (4 - k % 5));
      end
      held0  = pos - 4 * W - 4;
      held24 = pos;
    end else begin
      check_hold($sformatf("nowin@%0d", pos));
    end
    // Hand-computed taps from the first, row-wrap and last windows.
    case (pos)
      52: begin
        check_eq("first_t0", 32'(dout[0]), 0);
        check_eq("first_t4", 32'(dout[4]), 4);
        check_eq("first_t5", 32'(dout[5]), 12);
        check_eq("first_t20", 32'(dout[20]), 48);
        check_eq("first_t24", 32'(dout[24]), 52);
      end
      64: begin
        check_eq("wrap_t0", 32'(dout[0]), 12);
        check_eq("wrap_t24", 32'(dout[24]), 64);
      end
      143: begin
        check_eq("last_t0", 32'(dout[0]), 91);
        check_eq("last_t24", 32'(dout[24]), 143);
      end
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      @(posedge clk);
      #1;
      check_eq("idle_valid", 32'(valid_out_buf), 0);
      check_hold("idle");
    end
  endtask

  task automatic run_frame(input int max_gap);
    pulses = 0;
    for (int p = 0; p < N; p++) begin
      send(p);
      if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
    end
    check_eq("pulse_count", pulses, (W - 4) * (H - 4));
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    held0    = 0;
    held24   = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0);  // gap-free
    run_frame(0);  // back-to-back with the previous frame
    run_frame(5);  // random stalls between samples

    // Abandon a frame partway through row 6 and restart.
    for (int p = 0; p < 6 * W + 5; p++) send(p);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    check_all_zero("midreset_hold");
    held0  = 0;
    held24 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2_window_buf.md
Name: conv2_window_buf

Overview:
- Streaming 5x5 sliding-window generator for the second convolution stage of the MNIST CNN.
- Accepts one pooled feature-map sample per valid cycle, in raster order, from a WIDTH x HEIGHT map (12x12 default).
- Presents all 25 taps of the current 5x5 window in parallel, with a valid strobe, to the downstream multiply-accumulate calculators.
- One instance per input channel; instances run in lockstep.

Parameters:
- WIDTH, 12, feature-map columns per row (must be >= 5).
- HEIGHT, 12, feature-map rows per frame (must be >= 5).
- DATA_BITS, 12, sample width in bits; data is passed through untouched, with no arithmetic.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- valid_in  input  1  data_in carries a new sample this cycle.
- data_in  input  DATA_BITS  feature-map sample, raster order (row-major, column 0 first).
- data_out_0 .. data_out_24  output  DATA_BITS each  window taps. data_out_k is the window pixel at row k/5, column k%5. Tap 0 is top-left (oldest), tap 24 is bottom-right (newest).
- valid_out_buf  output  1  window taps are valid this cycle.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - column and row counters go to 0;
  - every storage element goes to 0;
  - all data_out_k go to 0;
  - valid_out_buf goes to 0.
- Storage: shift register of 4*WIDTH+5 entries (line buffer). It advances by one entry only on cycles with valid_in=1; otherwise it holds.
- Position counters track the (row, col) of each accepted sample:
  - col increments per accepted sample and wraps at WIDTH-1 to 0, incrementing row;
  - row wraps at HEIGHT-1 to 0, so the frame restarts seamlessly;
  - no idle cycle is required between frames.
- Window valid condition: the accepted sample is at row >= 4 and col >= 4. This excludes windows that would straddle a row boundary.
- Latency is one cycle, outputs registered. On an edge where valid_in=1 and the sample satisfies the valid condition:
  - next cycle valid_out_buf=1;
  - data_out_24 = that sample;
  - data_out_(5r+c) = sample at (row-4+r, col-4+c).
- valid_out_buf is a one-cycle pulse per qualifying sample. It is 0 on any cycle following valid_in=0 or a non-qualifying sample.
- data_out_k hold their last values while valid_out_buf=0. Downstream must sample them only when valid_out_buf=1.
- Window count: exactly (WIDTH-4)*(HEIGHT-4) pulses per frame, i.e. 64 for 12x12.
- Stalls: valid_in may deassert for any number of cycles mid-row or mid-frame. The output sequence is identical to gap-free input, only delayed.
- Reset mid-frame: the partial frame is discarded; the next accepted sample is treated as (0,0).
- No backpressure; the block always accepts data.

Optional Feature:
- Macro CONV2_WINDOW_FRAME_DONE_EN.
- Defined: adds output port frame_done (1 bit, reset 0). It pulses high for one cycle in the same cycle as the last window's valid_out_buf, i.e. after the sample at (HEIGHT-1, WIDTH-1) is accepted.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Gap-free 12x12 frame, sample value = raster index 0..143 -> first valid_out_buf one cycle after index 52 is accepted. Taps: data_out_0=0, data_out_4=4, data_out_5=12, data_out_20=48, data_out_24=52.
- Same frame, row boundary -> pulses for indices 52..59. No pulse for 60..63. Pulse for 64 with data_out_0=12, data_out_24=64.
- Full frame -> exactly 64 pulses. Last window: data_out_0=91, data_out_24=143. With CONV2_WINDOW_FRAME_DONE_EN, frame_done=1 in that same cycle.
- Random valid_in gaps of 0-5 cycles -> identical 64-window sequence to gap-free run; valid_out_buf never high after a valid_in=0 cycle.
- Two back-to-back frames (index mod 144) -> second frame's first pulse after its 53rd sample, data_out_0=0 (new frame's index 0), data_out_24=52.
- Assert rst_n=0 mid-way through row 6, then restart the frame -> all outputs 0 during reset; the restarted frame reproduces the gap-free scenario exactly.
